// File: rtl/gray_seq_ctrl.sv
// Sequencer for the binary-to-Gray datapath. It steps a binary index up or down and presents each binary/Gray pair.
// Latency: the first code is valid 1 clk after an accepted start. After that it emits one code per clk while out_ready is held high.
// Backpressure: while out_ready is low, out_valid/out_two/out_gray hold. It can stall indefinitely.
//
// Ports:
//   clk, rst (async active-low)              clock and reset
//   start, abort                             command inputs (start sampled in IDLE only)
//   cfg_dir, cfg_start, cfg_len              sequence configuration, latched on an accepted start
//   out_ready / out_valid, out_two, out_gray output code stream
//   busy, done                               status: busy in RUN, 1-cycle done after the last transfer
module gray_seq_ctrl #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             cfg_dir,
  input  logic [WIDTH-1:0] cfg_start,
  input  logic [WIDTH:0]   cfg_len,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_two,
  output logic [WIDTH-1:0] out_gray,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [WIDTH:0]   REM_ONE  = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   REM_ZERO = '0;
  localparam logic [WIDTH-1:0] STEP     = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] two_q, two_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic             dir_q, dir_d;

  logic             accept_start;
  logic             xfer;
  logic [WIDTH-1:0] two_step;

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  assign accept_start = (state_q == ST_IDLE) && start && (cfg_len != REM_ZERO);
  assign xfer         = (state_q == ST_RUN) && out_ready;
  // Wraps modulo 2^WIDTH naturally through the fixed-width add/subtract.
  assign two_step     = dir_q ? (two_q - STEP) : (two_q + STEP);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      two_q   <= '0;
      gray_q  <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      two_q   <= two_d;
      gray_q  <= gray_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
    end
  end

  // Next-state logic. Abort takes priority over start and over the final transfer.
  always_comb begin
    state_d = state_q;
    two_d   = two_q;
    gray_d  = gray_q;
    rem_d   = rem_q;
    dir_d   = dir_q;

    if (abort) begin
      state_d = ST_IDLE;
      rem_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept_start) begin
            state_d = ST_RUN;
            two_d   = cfg_start;
            gray_d  = to_gray(cfg_start);
            rem_d   = cfg_len;
            dir_d   = cfg_dir;
          end
        end
        ST_RUN: begin
          if (xfer) begin
            if (rem_q == REM_ONE) begin
              // The last code stays on out_two/out_gray after the run ends.
              state_d = ST_DONE;
              rem_d   = '0;
            end else begin
              rem_d   = rem_q - REM_ONE;
              two_d   = two_step;
              gray_d  = to_gray(two_step);
            end
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Output decode
  always_comb begin
    out_valid = (state_q == ST_RUN);
    busy      = (state_q == ST_RUN);
    done      = (state_q == ST_DONE);
    out_two   = two_q;
    out_gray  = gray_q;
  end

endmodule

// File: tb/tb_gray_seq_ctrl.sv
module tb_gray_seq_ctrl;

  typedef struct packed {
    logic [2:0] two;
    logic [2:0] gray;
  } code_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, abort, cfg_dir, out_ready;
  logic [2:0] cfg_start;
  logic [3:0] cfg_len;
  logic       out_valid, busy, done;
  logic [2:0] out_two, out_gray;

  int    checks = 0;
  int    errors = 0;
  code_t exp_q[$];
  int    done_exp = 0;

  gray_seq_ctrl #(.WIDTH(3)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cfg_dir(cfg_dir),
    .cfg_start(cfg_start), .cfg_len(cfg_len), .out_ready(out_ready),
    .out_valid(out_valid), .out_two(out_two), .out_gray(out_gray),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] t, input logic [2:0] g);
    code_t c;
    c.two  = t;
    c.gray = g;
    exp_q.push_back(c);
  endtask

  // Start is sampled at the next edge; the call returns 1 ns after it.
  task automatic do_start(input logic d, input logic [2:0] s, input logic [3:0] l);
    cfg_dir   = d;
    cfg_start = s;
    cfg_len   = l;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // Monitor: samples on the falling edge. A valid&ready pair seen here transfers at the next rising edge.
  initial begin : monitor
    int         cyc = 0;
    int         last_xfer_cyc = -10;
    logic       have_prev = 1'b0;
    logic [2:0] prev_gray = '0;
    logic       stall_prev = 1'b0;
    logic       abort_prev = 1'b0;
    logic [2:0] st_two = '0, st_gray = '0;
    code_t      e;
    forever begin
      @(negedge clk);
      cyc++;
      if (stall_prev && rst && !abort_prev) begin
        chk("stall_valid_held", {31'd0, out_valid}, 32'd1);
        chk("stall_two_held", {29'd0, out_two}, {29'd0, st_two});
        chk("stall_gray_held", {29'd0, out_gray}, {29'd0, st_gray});
      end
      stall_prev = out_valid && !out_ready;
      abort_prev = abort;
      st_two     = out_two;
      st_gray    = out_gray;
      if (!out_valid) have_prev = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_xfer: got two=%0d gray=%b expected none at %0t", out_two, out_gray, $time);
        end else begin
          e = exp_q.pop_front();
          chk("xfer_two", {29'd0, out_two}, {29'd0, e.two});
          chk("xfer_gray", {29'd0, out_gray}, {29'd0, e.gray});
        end
        if (have_prev)
          chk("gray_one_bit_step", $countones(out_gray ^ prev_gray), 32'd1);
        have_prev     = 1'b1;
        prev_gray     = out_gray;
        last_xfer_cyc = cyc;
      end
      if (done) begin
        if (done_exp == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected 0 at %0t", $time);
        end else begin
          done_exp--;
          chk("done_after_last_xfer", cyc, last_xfer_cyc + 1);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int pat[6] = '{1, 0, 0, 1, 0, 1};
    rst = 1'b0; start = 1'b0; abort = 1'b0; cfg_dir = 1'b0;
    cfg_start = '0; cfg_len = '0; out_ready = 1'b0;
    #3;
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_two", {29'd0, out_two}, 0);
    tick();
    rst = 1'b1;
    tick();

    // Full up sweep, back to back
    out_ready = 1'b1;
    push(0, 3'b000); push(1, 3'b001); push(2, 3'b011); push(3, 3'b010);
    push(4, 3'b110); push(5, 3'b111); push(6, 3'b101); push(7, 3'b100);
    done_exp++;
    do_start(1'b0, 3'd0, 4'd8);
    chk("sweep_first_two", {29'd0, out_two}, 0);
    for (int i = 0; i < 8; i++) begin
      chk("sweep_valid_each_clk", {31'd0, out_valid}, 1);
      tick();
    end
    chk("sweep_done_pulse", {31'd0, done}, 1);
    chk("sweep_busy_low", {31'd0, busy}, 0);
    tick();
    chk("sweep_done_one_cycle", {31'd0, done}, 0);

    // Down count across the 0->7 wrap
    push(1, 3'b001); push(0, 3'b000); push(7, 3'b100); push(6, 3'b101);
    done_exp++;
    do_start(1'b1, 3'd1, 4'd4);
    repeat (6) tick();

    // Backpressure
    out_ready = 1'b0;
    push(5, 3'b111); push(6, 3'b101); push(7, 3'b100);
    done_exp++;
    do_start(1'b0, 3'd5, 4'd3);
    for (int i = 0; i < 6; i++) begin
      out_ready = pat[i][0];
      tick();
    end
    out_ready = 1'b0;
    chk("bp_last_two_held", {29'd0, out_two}, 7);
    repeat (2) tick();

    // Zero-length start is rejected
    out_ready = 1'b1;
    do_start(1'b0, 3'd3, 4'd0);
    for (int i = 0; i < 3; i++) begin
      chk("reject_no_valid", {31'd0, out_valid}, 0);
      chk("reject_no_done", {31'd0, done}, 0);
      tick();
    end

    // Start while running is ignored, and cfg changes after start have no effect
    push(2, 3'b011); push(3, 3'b010); push(4, 3'b110); push(5, 3'b111);
    done_exp++;
    do_start(1'b0, 3'd2, 4'd4);
    tick();
    cfg_dir = 1'b1; cfg_start = 3'd6; cfg_len = 4'd8; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();

    // Abort after two of six transfers
    push(4, 3'b110); push(5, 3'b111);
    do_start(1'b0, 3'd4, 4'd6);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    out_ready = 1'b0;
    chk("abort_valid_low", {31'd0, out_valid}, 0);
    chk("abort_busy_low", {31'd0, busy}, 0);
    chk("abort_no_done", {31'd0, done}, 0);
    tick();
    chk("abort_no_done_later", {31'd0, done}, 0);
    out_ready = 1'b1;
    push(6, 3'b101); push(7, 3'b100);
    done_exp++;
    do_start(1'b0, 3'd6, 4'd2);
    repeat (4) tick();

    // Asynchronous reset in the middle of a run
    out_ready = 1'b0;
    do_start(1'b0, 3'd3, 4'd8);
    chk("pre_rst_valid", {31'd0, out_valid}, 1);
    #2 rst = 1'b0;
    #1;
    chk("midrun_rst_valid", {31'd0, out_valid}, 0);
    chk("midrun_rst_busy", {31'd0, busy}, 0);
    chk("midrun_rst_two", {29'd0, out_two}, 0);
    chk("midrun_rst_gray", {29'd0, out_gray}, 0);
    tick();
    rst = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_idle", {31'd0, out_valid}, 0);
    end

    chk("all_codes_seen", exp_q.size(), 0);
    chk("all_dones_seen", done_exp, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
